// File: rtl/clock_pkg.sv
// Shared encodings, key indices and field limits for the clock controller.
// The wrap-aware step function is used for both time and alarm editing.
package clock_pkg;

   typedef enum logic [1:0] {
      ModeRun      = 2'd0,
      ModeSetTime  = 2'd1,
      ModeSetAlarm = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      FieldHour = 2'd0,
      FieldMin  = 2'd1,
      FieldSec  = 2'd2
   } field_e;

   localparam int unsigned KEY_MODE  = 0;
   localparam int unsigned KEY_FIELD = 1;
   localparam int unsigned KEY_INC   = 2;
   localparam int unsigned KEY_DEC   = 3;
   localparam int unsigned KEY_ALM   = 4;

   localparam logic [5:0] HOUR_MAX   = 6'd23;
   localparam logic [5:0] MINSEC_MAX = 6'd59;

   // One step up or down with wrap at 0 and max_val; neighbours are untouched.
   function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max_val,
                                            input logic up);
      logic [5:0] res;
      if (up) begin
         res = (val >= max_val) ? 6'd0 : val + 6'd1;
      end else begin
         res = (val == 6'd0) ? max_val : val - 6'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: one-cycle sec_tick per CLK_FREQ cycles and a half-second blink phase.
// clr restarts the count so the next second is a full one.
module tick_gen #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic sec_tick,
   output logic blink
);

   localparam int unsigned CntW = $clog2(CLK_FREQ);
   localparam logic [CntW-1:0] CntLast = CntW'(CLK_FREQ - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLK_FREQ / 2 - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick_q, tick_d;
   logic            blink_q, blink_d;

   always_comb begin
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      blink_d = blink_q;
      if (clr) begin
         cnt_d   = '0;
         blink_d = 1'b0;
      end else begin
         cnt_d   = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
         tick_d  = (cnt_q == CntLast);
         blink_d = blink_q ^ ((cnt_q == CntLast) || (cnt_q == CntHalf));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         blink_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         blink_q <= blink_d;
      end
   end

   assign sec_tick = tick_q;
   assign blink    = blink_q;

endmodule

// File: rtl/clock_ctrl.sv
// Time-of-day clock with alarm and a key-driven mode/field setting FSM.
// All outputs come straight from registers.
module clock_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned RING_SECS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_in,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [4:0] alm_hour,
   output logic [5:0] alm_minute,
   output logic [1:0] mode,
   output logic [1:0] field,
   output logic       alarm_en,
   output logic       alarm_ring,
   output logic       blink,
   output logic       sec_tick
);

   localparam logic [7:0] RingLast = 8'(RING_SECS - 1);

   mode_e      mode_q, mode_d;
   field_e     field_q, field_d;
   logic [4:0] hour_q, hour_d, alm_hour_q, alm_hour_d;
   logic [5:0] minute_q, minute_d, second_q, second_d, alm_minute_q, alm_minute_d;
   logic       alarm_en_q, alarm_en_d, ring_q, ring_d;
   logic [7:0] ring_cnt_q, ring_cnt_d;

   logic tick, blink_int, clr, edit, tick_run;
   logic act_mode, act_field, act_inc, act_dec, act_alm;

   tick_gen #(
      .CLK_FREQ(CLK_FREQ)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .sec_tick(tick),
      .blink   (blink_int)
   );

   // Only the lowest-indexed pressed key acts in a cycle.
   assign act_mode  = key_in[KEY_MODE];
   assign act_field = key_in[KEY_FIELD] & ~key_in[KEY_MODE];
   assign act_inc   = key_in[KEY_INC] & ~(key_in[KEY_MODE] | key_in[KEY_FIELD]);
   assign act_dec   = key_in[KEY_DEC] & ~(key_in[KEY_MODE] | key_in[KEY_FIELD] | key_in[KEY_INC]);
   assign act_alm   = key_in[KEY_ALM] & ~(|key_in[3:0]);

   assign clr      = act_mode && (mode_q == ModeSetTime);
   assign edit     = (act_inc || act_dec) && (mode_q != ModeRun);
   assign tick_run = tick && (mode_q != ModeSetTime);

   always_comb begin
      mode_d       = mode_q;
      field_d      = field_q;
      hour_d       = hour_q;
      minute_d     = minute_q;
      second_d     = second_q;
      alm_hour_d   = alm_hour_q;
      alm_minute_d = alm_minute_q;
      alarm_en_d   = alarm_en_q;
      ring_d       = ring_q;
      ring_cnt_d   = ring_cnt_q;

      if (act_mode) begin
         field_d = FieldHour;
         case (mode_q)
            ModeRun:     mode_d = ModeSetTime;
            ModeSetTime: mode_d = ModeSetAlarm;
            default:     mode_d = ModeRun;
         endcase
      end else if (act_field && (mode_q != ModeRun)) begin
         case (field_q)
            FieldHour: field_d = FieldMin;
            FieldMin:  field_d = (mode_q == ModeSetAlarm) ? FieldHour : FieldSec;
            default:   field_d = FieldHour;
         endcase
      end

      if (edit && (mode_q == ModeSetTime)) begin
         case (field_q)
            FieldHour: hour_d   = 5'(wrap_step({1'b0, hour_q}, HOUR_MAX, act_inc));
            FieldMin:  minute_d = wrap_step(minute_q, MINSEC_MAX, act_inc);
            default:   second_d = wrap_step(second_q, MINSEC_MAX, act_inc);
         endcase
      end else if (edit && (mode_q == ModeSetAlarm)) begin
         case (field_q)
            FieldHour: alm_hour_d   = 5'(wrap_step({1'b0, alm_hour_q}, HOUR_MAX, act_inc));
            FieldMin:  alm_minute_d = wrap_step(alm_minute_q, MINSEC_MAX, act_inc);
            default:   ;
         endcase
      end

      if (tick_run) begin
         if (second_d == MINSEC_MAX) begin
            second_d = '0;
            if (minute_d == MINSEC_MAX) begin
               minute_d = '0;
               hour_d   = (hour_d == 5'(HOUR_MAX)) ? '0 : hour_d + 5'd1;
            end else begin
               minute_d = minute_d + 6'd1;
            end
         end else begin
            second_d = second_d + 6'd1;
         end
      end

      if (act_alm && !ring_q) begin
         alarm_en_d = ~alarm_en_q;
      end

      // Ring duration counts every elapsed second, even while time is frozen.
      if (ring_q) begin
         if (act_alm || !alarm_en_d) begin
            ring_d = 1'b0;
         end else if (tick) begin
            if (ring_cnt_q == RingLast) begin
               ring_d = 1'b0;
            end else begin
               ring_cnt_d = ring_cnt_q + 8'd1;
            end
         end
      end else if (tick_run && alarm_en_d && (hour_d == alm_hour_d) &&
                   (minute_d == alm_minute_d) && (second_d == 6'd0)) begin
         ring_d     = 1'b1;
         ring_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= ModeRun;
         field_q      <= FieldHour;
         hour_q       <= '0;
         minute_q     <= '0;
         second_q     <= '0;
         alm_hour_q   <= '0;
         alm_minute_q <= '0;
         alarm_en_q   <= 1'b0;
         ring_q       <= 1'b0;
         ring_cnt_q   <= '0;
      end else begin
         mode_q       <= mode_d;
         field_q      <= field_d;
         hour_q       <= hour_d;
         minute_q     <= minute_d;
         second_q     <= second_d;
         alm_hour_q   <= alm_hour_d;
         alm_minute_q <= alm_minute_d;
         alarm_en_q   <= alarm_en_d;
         ring_q       <= ring_d;
         ring_cnt_q   <= ring_cnt_d;
      end
   end

   assign hour       = hour_q;
   assign minute     = minute_q;
   assign second     = second_q;
   assign alm_hour   = alm_hour_q;
   assign alm_minute = alm_minute_q;
   assign mode       = mode_q;
   assign field      = field_q;
   assign alarm_en   = alarm_en_q;
   assign alarm_ring = ring_q;
   assign blink      = blink_int;
   assign sec_tick   = tick;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed scenarios plus random keys against a seconds-of-day model.
module tb_clock_ctrl;

   localparam int CF = 10;
   localparam int RS = 3;

   localparam logic [4:0] K_MODE  = 5'b00001;
   localparam logic [4:0] K_FIELD = 5'b00010;
   localparam logic [4:0] K_INC   = 5'b00100;
   localparam logic [4:0] K_DEC   = 5'b01000;
   localparam logic [4:0] K_ALM   = 5'b10000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] key_in = '0;
   logic [4:0] hour, alm_hour;
   logic [5:0] minute, second, alm_minute;
   logic [1:0] mode, field;
   logic       alarm_en, alarm_ring, blink, sec_tick;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: time as seconds of day, alarm as minutes of day, m_n = cycles since prescaler clear.
   int m_tod, m_alm, m_mode, m_field, m_en, m_ring, m_ring_left, m_n;

   always #5 clk = ~clk;

   clock_ctrl #(
      .CLK_FREQ (CF),
      .RING_SECS(RS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .hour      (hour),
      .minute    (minute),
      .second    (second),
      .alm_hour  (alm_hour),
      .alm_minute(alm_minute),
      .mode      (mode),
      .field     (field),
      .alarm_en  (alarm_en),
      .alarm_ring(alarm_ring),
      .blink     (blink),
      .sec_tick  (sec_tick)
   );

   function automatic bit exp_tick();
      return (m_n > 0) && (m_n % CF == 0);
   endfunction

   function automatic bit exp_blink();
      return ((m_n / (CF / 2)) % 2) == 1;
   endfunction

   task automatic model_reset();
      m_tod = 0; m_alm = 0; m_mode = 0; m_field = 0;
      m_en = 0; m_ring = 0; m_ring_left = 0; m_n = 0;
   endtask

   task automatic model_step(input logic [4:0] k);
      int act, h, mi, s, ah, am, d, old;
      bit tick_now, tick_run, clr, ack;
      tick_now = exp_tick();
      old = m_mode;
      act = -1;
      for (int i = 4; i >= 0; i--) if (k[i]) act = i;
      clr = 0; ack = 0;
      h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
      ah = m_alm / 60; am = m_alm % 60;
      d = (act == 2) ? 1 : -1;
      case (act)
         0: begin clr = (old == 1); m_mode = (old + 1) % 3; m_field = 0; end
         1: if (old != 0) m_field = (m_field + 1) % ((old == 2) ? 2 : 3);
         2, 3: begin
            if (old == 1) begin
               if (m_field == 0) h = (h + 24 + d) % 24;
               else if (m_field == 1) mi = (mi + 60 + d) % 60;
               else s = (s + 60 + d) % 60;
               m_tod = h * 3600 + mi * 60 + s;
            end else if (old == 2) begin
               if (m_field == 0) ah = (ah + 24 + d) % 24;
               else am = (am + 60 + d) % 60;
               m_alm = ah * 60 + am;
            end
         end
         4: if (m_ring != 0) ack = 1; else m_en = (m_en == 0) ? 1 : 0;
         default: ;
      endcase
      tick_run = tick_now && (old != 1);
      if (tick_run) m_tod = (m_tod + 1) % 86400;
      if (m_ring != 0) begin
         if (ack) m_ring = 0;
         else if (tick_now) begin
            m_ring_left--;
            if (m_ring_left == 0) m_ring = 0;
         end
      end else if (tick_run && (m_en != 0) && (m_tod == m_alm * 60)) begin
         m_ring = 1; m_ring_left = RS;
      end
      m_n = clr ? 0 : m_n + 1;
   endtask

   task automatic step(input logic [4:0] k);
      model_step(k);
      key_in = k;
      @(posedge clk);
      #1;
      key_in = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      key_in = 5'($urandom_range(0, 31));
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      key_in = '0;
   endtask

   task automatic setup_alarm();
      do_reset();
      step(K_MODE); step(K_FIELD); step(K_FIELD); step(K_DEC); step(K_DEC);
      step(K_MODE); step(K_FIELD); step(K_INC); step(K_ALM); step(K_MODE);
   endtask

   task automatic wait_ring(input string name);
      for (int i = 0; i < 200 && alarm_ring !== 1'b1; i++) step('0);
      n_cmp++;
      if (alarm_ring !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ring_timeout: got ring=%b expected 1 within 200 cycles", name, alarm_ring);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(K_INC);
      do_reset();
      n_cmp++;
      if ({hour, minute, second, alm_hour, alm_minute} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_regs: got %h expected 0", {hour, minute, second, alm_hour, alm_minute});
      end
      n_cmp++;
      if ({mode, field, alarm_en, alarm_ring, blink, sec_tick} !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0", {mode, field, alarm_en, alarm_ring, blink,
                  sec_tick});
      end
   endtask

   task automatic test_run_ticks();
      int highs;
      highs = 0;
      for (int i = 0; i < 25 * CF + 1; i++) begin
         step('0);
         if (sec_tick === 1'b1) highs++;
         n_cmp++;
         if (sec_tick !== exp_tick() || blink !== exp_blink()) begin
            n_fail++;
            $display("FAIL run_tick_blink: cycle %0d got tick=%b blink=%b expected %b %b", i,
                     sec_tick, blink, exp_tick(), exp_blink());
         end
      end
      n_cmp++;
      if (second !== 6'd25 || minute !== 6'd0 || highs != 25) begin
         n_fail++;
         $display("FAIL run_25s: got sec=%0d min=%0d ticks=%0d expected 25 0 25", second, minute,
                  highs);
      end
   endtask

   task automatic test_set_time();
      do_reset();
      step(K_MODE); step(K_DEC);
      n_cmp++;
      if (hour !== 5'd23 || mode !== 2'd1) begin
         n_fail++;
         $display("FAIL set_hour_dec: got hour=%0d mode=%0d expected 23 1", hour, mode);
      end
      step(K_FIELD); step(K_DEC);
      n_cmp++;
      if (minute !== 6'd59 || field !== 2'd1) begin
         n_fail++;
         $display("FAIL set_min_dec: got min=%0d field=%0d expected 59 1", minute, field);
      end
      step(K_FIELD); step(K_DEC);
      n_cmp++;
      if (second !== 6'd59 || field !== 2'd2) begin
         n_fail++;
         $display("FAIL set_sec_dec: got sec=%0d field=%0d expected 59 2", second, field);
      end
      step(K_MODE); step(K_MODE);
      n_cmp++;
      if (mode !== 2'd0 || field !== 2'd0) begin
         n_fail++;
         $display("FAIL set_back_run: got mode=%0d field=%0d expected 0 0", mode, field);
      end
      for (int i = 0; i < CF - 1; i++) step('0);
      n_cmp++;
      if ({hour, minute, second} !== {5'd23, 6'd59, 6'd59}) begin
         n_fail++;
         $display("FAIL set_before_wrap: got %0d:%0d:%0d expected 23:59:59", hour, minute, second);
      end
      step('0);
      n_cmp++;
      if ({hour, minute, second} !== 17'd0) begin
         n_fail++;
         $display("FAIL set_day_wrap: got %0d:%0d:%0d expected 0:0:0", hour, minute, second);
      end
   endtask

   task automatic test_freeze();
      int saved, cnt;
      step(K_MODE);
      saved = m_tod;
      for (int i = 0; i < 30; i++) step('0);
      n_cmp++;
      if ({hour, minute, second} !== {5'(saved / 3600), 6'((saved / 60) % 60), 6'(saved % 60)}) begin
         n_fail++;
         $display("FAIL freeze_time: got %0d:%0d:%0d expected tod %0d", hour, minute, second, saved);
      end
      step(K_MODE);
      cnt = 1;
      step(K_MODE);
      while (sec_tick !== 1'b1 && cnt < 40) begin
         step('0);
         cnt++;
      end
      n_cmp++;
      if (cnt != CF || mode !== 2'd0) begin
         n_fail++;
         $display("FAIL freeze_exit_tick: got %0d cycles mode=%0d expected %0d 0", cnt, mode, CF);
      end
   endtask

   task automatic test_priority();
      int saved_h;
      step(K_MODE);
      saved_h = m_tod / 3600;
      step(5'b00101);
      n_cmp++;
      if (mode !== 2'd2 || hour !== 5'(saved_h) || field !== 2'd0) begin
         n_fail++;
         $display("FAIL key_priority: got mode=%0d hour=%0d field=%0d expected 2 %0d 0", mode,
                  hour, field, saved_h);
      end
      step(K_MODE);
   endtask

   task automatic test_alarm();
      setup_alarm();
      n_cmp++;
      if ({alm_hour, alm_minute, alarm_en, mode, second} !== {5'd0, 6'd1, 1'b1, 2'd0, 6'd58}) begin
         n_fail++;
         $display("FAIL alarm_setup: got alm=%0d:%0d en=%b mode=%0d sec=%0d expected 0:1 1 0 58",
                  alm_hour, alm_minute, alarm_en, mode, second);
      end
      wait_ring("alarm");
      n_cmp++;
      if ({hour, minute, second} !== {5'd0, 6'd1, 6'd0}) begin
         n_fail++;
         $display("FAIL alarm_rise_time: got %0d:%0d:%0d expected 0:1:0", hour, minute, second);
      end
      for (int i = 0; i < 100 && alarm_ring === 1'b1; i++) step('0);
      n_cmp++;
      if (alarm_ring !== 1'b0 || second !== 6'd3 || minute !== 6'd1 || alarm_en !== 1'b1) begin
         n_fail++;
         $display("FAIL alarm_fall: got ring=%b sec=%0d min=%0d en=%b expected 0 3 1 1",
                  alarm_ring, second, minute, alarm_en);
      end
   endtask

   task automatic test_ack();
      setup_alarm();
      wait_ring("ack");
      step('0); step('0);
      step(K_ALM);
      n_cmp++;
      if (alarm_ring !== 1'b0 || alarm_en !== 1'b1) begin
         n_fail++;
         $display("FAIL alarm_ack: got ring=%b en=%b expected 0 1", alarm_ring, alarm_en);
      end
   endtask

   task automatic test_reset_ringing();
      setup_alarm();
      wait_ring("rst");
      step(K_MODE); step(K_MODE);
      n_cmp++;
      if (mode !== 2'd2 || alarm_ring !== 1'b1) begin
         n_fail++;
         $display("FAIL ring_in_set_alarm: got mode=%0d ring=%b expected 2 1", mode, alarm_ring);
      end
      do_reset();
      n_cmp++;
      if ({hour, minute, second, alm_hour, alm_minute, mode, field, alarm_en, alarm_ring, blink,
           sec_tick} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_while_ringing: got %h expected 0", {hour, minute, second, alm_hour,
                  alm_minute, mode, field, alarm_en, alarm_ring, blink, sec_tick});
      end
   endtask

   task automatic test_random();
      logic [4:0] k;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         k = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         if ($urandom_range(0, 999) == 0) do_reset();
         else step(k);
         n_cmp++;
         if ({hour, minute, second} !== {5'(m_tod / 3600), 6'((m_tod / 60) % 60), 6'(m_tod % 60)})
         begin
            n_fail++;
            $display("FAIL rand_time: cycle %0d got %0d:%0d:%0d expected tod %0d", i, hour, minute,
                     second, m_tod);
         end
         n_cmp++;
         if ({alm_hour, alm_minute} !== {5'(m_alm / 60), 6'(m_alm % 60)}) begin
            n_fail++;
            $display("FAIL rand_alarm: cycle %0d got %0d:%0d expected min %0d", i, alm_hour,
                     alm_minute, m_alm);
         end
         n_cmp++;
         if ({mode, field} !== {2'(m_mode), 2'(m_field)}) begin
            n_fail++;
            $display("FAIL rand_mode: cycle %0d got mode=%0d field=%0d expected %0d %0d", i, mode,
                     field, m_mode, m_field);
         end
         n_cmp++;
         if ({alarm_en, alarm_ring, blink, sec_tick} !==
             {m_en[0], m_ring[0], exp_blink(), exp_tick()}) begin
            n_fail++;
            $display("FAIL rand_flags: cycle %0d got %b expected %b", i,
                     {alarm_en, alarm_ring, blink, sec_tick},
                     {m_en[0], m_ring[0], exp_blink(), exp_tick()});
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run_ticks();
      test_set_time();
      test_freeze();
      test_priority();
      test_alarm();
      test_ack();
      test_reset_ringing();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Consumes the single-cycle key pulses from the key debouncer/edge detector. Runs the electronic clock's time-of-day counter and alarm.
- Provides a mode/field setting state machine driven by the keys.
- Feeds the display driver with binary time, alarm time, the selected field and a blink phase.

Parameters:
- CLK_FREQ, 50_000_000, clk cycles per second; sets the 1 Hz tick. Must be even and >= 4.
- RING_SECS, 60, seconds alarm_ring stays asserted unless acknowledged; range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- key_in  input  5  one-cycle key pulses: [0] mode, [1] field, [2] inc, [3] dec, [4] alarm toggle/ack
- hour  output  5  current hour, 0..23
- minute  output  6  current minute, 0..59
- second  output  6  current second, 0..59
- alm_hour  output  5  alarm hour, 0..23
- alm_minute  output  6  alarm minute, 0..59
- mode  output  2  0 RUN, 1 SET_TIME, 2 SET_ALARM
- field  output  2  0 HOUR, 1 MIN, 2 SEC (valid in set modes)
- alarm_en  output  1  alarm armed
- alarm_ring  output  1  alarm active
- blink  output  1  0.5 s-period-half phase for flashing the selected field
- sec_tick  output  1  one-cycle pulse per elapsed second

Behaviour:
- Reset, clock edge with rst=1:
  - all time and alarm registers 0; mode RUN; field HOUR.
  - alarm_en 0, alarm_ring 0, blink 0, sec_tick 0, prescaler 0.
- Prescaler:
  - counts 0..CLK_FREQ-1.
  - sec_tick is high in the cycle after the count reaches CLK_FREQ-1.
  - blink toggles when the count reaches CLK_FREQ/2-1 and CLK_FREQ-1.
- Key priority: when several key_in bits are high in one cycle, only the highest-priority one acts: mode > field > inc > dec > key[4]. The others are ignored.
- Mode FSM, on key[0]: RUN -> SET_TIME -> SET_ALARM -> RUN.
  - Each mode change sets field to HOUR.
  - Leaving SET_TIME clears the prescaler and blink, so the first second after setting is a full second.
- key[1] in set modes: field cycles HOUR -> MIN -> SEC -> HOUR. In SET_ALARM, SEC is skipped (HOUR -> MIN -> HOUR). Ignored in RUN.
- key[2]/key[3] in set modes: increment/decrement the selected field of the time (SET_TIME) or alarm (SET_ALARM). The register updates the next cycle.
  - Wrap: 23->0 and 0->23 for hours; 59->0 and 0->59 for minutes/seconds.
  - No carry into neighbouring fields.
  - Ignored in RUN.
- Timekeeping: in RUN and SET_ALARM, each tick advances second.
  - 59 -> 0 carries into minute; 59 -> 0 carries into hour; 23:59:59 -> 00:00:00.
  - In SET_TIME, time is frozen and ticks are discarded.
  - An inc/dec in the same cycle as a tick: the key is applied and the tick is applied after it (SET_ALARM edits alarm, time still advances).
- Alarm:
  - key[4] outside ringing toggles alarm_en.
  - alarm_ring sets on the cycle the time becomes alm_hour:alm_minute:00, when alarm_en=1 and mode≠SET_TIME.
  - alarm_ring clears after RING_SECS ticks, on key[4], or on alarm_en cleared.
  - key[4] while ringing only acknowledges; alarm_en is unchanged.
- Mid-operation reset behaves as the reset case on the next edge, regardless of mode or ringing state.
- Outputs are registered; no combinational path from key_in to outputs.

Decomposition:
- clock_pkg holds:
  - mode encodings RUN/SET_TIME/SET_ALARM
  - field encodings HOUR/MIN/SEC
  - key index constants KEY_MODE..KEY_ALM
  - limits 23/59
- Sub-module tick_gen (parameter CLK_FREQ):
  - inputs clk, rst, clr
  - outputs sec_tick, blink
- The wrap-aware inc/dec is a package function.

Test Plan (CLK_FREQ=10, RING_SECS=3):
- Reset, then 25 ticks in RUN -> second=25, minute=0; blink toggles every 5 cycles; sec_tick is exactly 1 cycle wide.
- Set time:
  - mode once, dec once -> hour=23.
  - field, dec -> minute=59.
  - field, dec -> second=59.
  - mode twice -> RUN.
  - 10 cycles later -> 00:00:00.
- Hold 30 cycles in SET_TIME -> time unchanged. Exit to RUN -> first tick 10 cycles after exit.
- key_in=5'b00101 in SET_TIME -> only mode advances to SET_ALARM; no increment.
- Alarm:
  - set alarm 00:01, key[4] -> alarm_en=1.
  - run from 00:00:58 -> alarm_ring rises at 00:01:00 and falls 3 ticks later.
  - repeat, pressing key[4] mid-ring -> ring clears, alarm_en stays 1.
- Assert rst while ringing in SET_ALARM -> next cycle all outputs at reset values.
